// File: rtl/pull_fifo.sv
// pull_fifo: 8-bit FIFO pulled at both ends (Wishbone controller upstream, device downstream).
// Optional PULL_FIFO_FETCH_ADR_EN adds an incrementing upstream fetch address (wb_up_adr_o).
`timescale 1ns/1ps
module pull_fifo #(
    parameter int ADDR_WIDTH      = 4,
    parameter int FETCH_ADR_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
`ifdef PULL_FIFO_FETCH_ADR_EN
    output logic [FETCH_ADR_WIDTH-1:0] wb_up_adr_o,
`endif
    output logic                       wb_up_cyc_o,
    output logic                       wb_up_stb_o,
    output logic                       wb_up_we_o,
    input  logic                       wb_up_stall_i,
    input  logic                       wb_up_ack_i,
    input  logic [7:0]                 wb_up_dat_i,
    input  logic                       wb_dn_cyc_i,
    input  logic                       wb_dn_stb_i,
    input  logic                       wb_dn_we_i,
    output logic                       wb_dn_stall_o,
    output logic                       wb_dn_ack_o,
    output logic [7:0]                 wb_dn_dat_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                  ack_q, ack_d;
    logic [7:0]            dat_q, dat_d;
    logic [7:0]            mem_q [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic accept;
    logic pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign wb_dn_stall_o = wb_dn_cyc_i && wb_dn_stb_i && empty;

    // Only an ack that answers our outstanding request stores data.
    assign push   = (state_q == S_WAIT_ACK) && wb_up_ack_i;
    assign accept = wb_dn_cyc_i && wb_dn_stb_i && !wb_dn_stall_o;
    assign pop    = accept && !wb_dn_we_i;

    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(pop);
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(push);
        ack_d    = accept;
        dat_d    = pop ? mem_q[rd_ptr_q] : 8'h00;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!full) state_d = S_REQ;
            end
            S_REQ: begin
                if (!wb_up_stall_i) state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // Chain straight into the next request while space remains.
                if (wb_up_ack_i) begin
                    state_d = (count_d < CW'(DEPTH)) ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cyc_d = (state_d != S_IDLE);
        stb_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ack_q    <= 1'b0;
            dat_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_q[wr_ptr_q] <= wb_up_dat_i;
        end
    end

`ifdef PULL_FIFO_FETCH_ADR_EN
    logic [FETCH_ADR_WIDTH-1:0] adr_q, adr_d;

    assign adr_d = adr_q + FETCH_ADR_WIDTH'(push);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adr_q <= '0;
        end else begin
            adr_q <= adr_d;
        end
    end

    assign wb_up_adr_o = adr_q;
`endif

    assign wb_up_cyc_o = cyc_q;
    assign wb_up_stb_o = stb_q;
    assign wb_up_we_o  = 1'b0;
    assign wb_dn_ack_o = ack_q;
    assign wb_dn_dat_o = dat_q;

endmodule
